// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter MMIO block: event indices,
// register offsets and the word access encoding.
package perf_pkg;

    localparam int NUM_EVT = 9;
    localparam int NUM_CNT = NUM_EVT + 1;

    localparam logic [2:0] RW_WORD = 3'b010;

    localparam logic [7:0] OFF_CYCLE = 8'h24;
    localparam logic [7:0] OFF_CTRL  = 8'h28;
    localparam logic [7:0] OFF_OVF   = 8'h2C;
    localparam logic [7:0] OFF_END   = 8'h30;

    typedef enum logic [3:0] {
        EVT_BEQ,
        EVT_BNE,
        EVT_BLT,
        EVT_BGE,
        EVT_BLTU,
        EVT_BGEU,
        EVT_JAL,
        EVT_JALR,
        EVT_FLUSH,
        EVT_CYCLE
    } evt_idx_e;

endpackage

// File: rtl/perf_counter_mmio_if.sv
// Core data-memory bus as seen by a memory-mapped responder.
// master = core side, slave = responder side.
interface perf_counter_mmio_if;

    logic        W_en;
    logic        R_en;
    logic [31:0] ram_addr;
    logic [2:0]  RW_type;
    logic [31:0] din;
    logic [31:0] dout;
    logic        sel;
    logic        access_err;

    modport master (
        output W_en, R_en, ram_addr, RW_type, din,
        input  dout, sel, access_err
    );

    modport slave (
        input  W_en, R_en, ram_addr, RW_type, din,
        output dout, sel, access_err
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with clear > load > increment priority.
// ovf_set flags an increment that arrives while already at all-ones (event lost).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         ovf_set
);

    logic [W-1:0] r_q;
    logic         w_full;
    logic         w_step;

    assign w_full  = &r_q;
    assign w_step  = en & inc & ~clr & ~ld;
    assign ovf_set = w_step & w_full;
    assign q       = r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= ld_val;
        end else if (w_step && !w_full) begin
            r_q <= r_q + 1'b1;
        end
    end

endmodule

// File: rtl/perf_counter_mmio.sv
// Memory-mapped saturating performance counters sitting beside data memory.
// Reads are zero-latency combinational, writes land on the next edge; never stalls the core.
module perf_counter_mmio
    import perf_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter int          CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EVT-1:0] evt,
    perf_counter_mmio_if.slave bus
);

    logic [7:0]         w_off;
    logic [5:0]         w_idx;
    logic               w_in_win;
    logic               w_sel;
    logic               w_legal;
    logic               w_wr;
    logic               w_ctrl_wr;
    logic               w_clr;
    logic               w_ovf_wr;
    logic [NUM_CNT-1:0] w_ovf_w1c;
    logic [NUM_CNT-1:0] w_inc;
    logic [NUM_CNT-1:0] w_ovf_set;
    logic [CNT_W-1:0]   w_cnt [NUM_CNT];
    logic [31:0]        w_rdata;

    logic               r_ctrl_en;
    logic [NUM_CNT-1:0] r_ovf;
    logic               r_err;

    assign w_off     = bus.ram_addr[7:0];
    assign w_idx     = w_off[7:2];
    assign w_in_win  = (bus.ram_addr[31:8] == BASE_ADDR[31:8]);
    assign w_sel     = w_in_win & (bus.R_en | bus.W_en);
    assign w_legal   = w_sel & (bus.RW_type == RW_WORD) & (w_off[1:0] == 2'b00) & (w_off < OFF_END);
    assign w_wr      = w_legal & bus.W_en;
    assign w_ctrl_wr = w_wr & (w_off == OFF_CTRL);
    assign w_clr     = w_ctrl_wr & bus.din[1];
    assign w_ovf_wr  = w_wr & (w_off == OFF_OVF);
    assign w_ovf_w1c = w_ovf_wr ? bus.din[NUM_CNT-1:0] : '0;

    // The top counter is CYCLE and counts every enabled clock.
    assign w_inc = {1'b1, evt};

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (w_clr),
            .ld      (w_wr && (w_idx == 6'(g))),
            .ld_val  (bus.din[CNT_W-1:0]),
            .inc     (w_inc[g]),
            .en      (r_ctrl_en),
            .q       (w_cnt[g]),
            .ovf_set (w_ovf_set[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_en <= 1'b1;
            r_ovf     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_sel & ~w_legal;
            if (w_ctrl_wr) begin
                r_ctrl_en <= bus.din[0];
            end
            // W1C beats a same-edge overflow only on the bits software wrote as 1.
            if (w_clr) begin
                r_ovf <= '0;
            end else begin
                r_ovf <= (r_ovf | w_ovf_set) & ~w_ovf_w1c;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (w_idx == 6'(i)) begin
                w_rdata[CNT_W-1:0] = w_cnt[i];
            end
        end
        if (w_off == OFF_CTRL) begin
            w_rdata[0] = r_ctrl_en;
        end else if (w_off == OFF_OVF) begin
            w_rdata[NUM_CNT-1:0] = r_ovf;
        end
    end

    assign bus.dout       = (w_legal & bus.R_en) ? w_rdata : '0;
    assign bus.sel        = w_sel;
    assign bus.access_err = r_err;

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Bench for perf_counter_mmio: a 32-bit and a 4-bit instance driven against
// an arithmetic reference model of the register map.
module tb_perf_counter_mmio;
    import perf_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_F000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] evt0;
    logic [8:0] evt1;

    always #5 clk = ~clk;

    perf_counter_mmio_if bus0 ();
    perf_counter_mmio_if bus1 ();

    perf_counter_mmio #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .evt(evt0), .bus(bus0.slave)
    );
    perf_counter_mmio #(.BASE_ADDR(BASE), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .evt(evt1), .bus(bus1.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state, index 0 = 32-bit instance, 1 = 4-bit instance.
    longint unsigned m_cnt [2][10];
    bit              m_en  [2];
    bit [9:0]        m_ovf [2];
    bit              m_err [2];
    int              m_w   [2] = '{32, 4};

    logic [31:0] od, ed;
    logic        os, es, oe, ee;

    function automatic longint unsigned m_max(int d);
        return (64'd1 << m_w[d]) - 64'd1;
    endfunction

    function automatic bit m_sel(logic [31:0] a, bit r, bit w);
        return (a[31:8] == BASE[31:8]) && (r || w);
    endfunction

    function automatic bit m_legal(logic [31:0] a, logic [2:0] t, bit r, bit w);
        return m_sel(a, r, w) && (t == 3'b010) && (a[1:0] == 2'b00) && (a[7:0] < 8'h30);
    endfunction

    function automatic logic [31:0] m_read(int d, logic [31:0] a, logic [2:0] t, bit r, bit w);
        int off;
        off = int'(a[7:0]);
        if (!r || !m_legal(a, t, r, w)) return 32'd0;
        if (off < 'h28) return 32'(m_cnt[d][off / 4]);
        if (off == 'h28) return {31'd0, m_en[d]};
        return {22'd0, m_ovf[d]};
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 10; i++) m_cnt[d][i] = 0;
            m_en[d]  = 1'b1;
            m_ovf[d] = '0;
            m_err[d] = 1'b0;
        end
    endtask

    task automatic m_edge(int d, bit w, bit r, logic [31:0] a, logic [2:0] t,
                          logic [31:0] data, logic [8:0] ev);
        bit       lg, wr, clr, inc;
        int       off;
        bit [9:0] newovf;
        lg     = m_legal(a, t, r, w);
        wr     = lg && w;
        off    = int'(a[7:0]);
        clr    = wr && (off == 'h28) && data[1];
        newovf = '0;
        for (int i = 0; i < 10; i++) begin
            inc = (i == 9) ? 1'b1 : ev[i];
            if (clr) m_cnt[d][i] = 0;
            else if (wr && off == 4 * i) m_cnt[d][i] = longint'(data) & m_max(d);
            else if (m_en[d] && inc) begin
                if (m_cnt[d][i] == m_max(d)) newovf[i] = 1'b1;
                else m_cnt[d][i] = m_cnt[d][i] + 1;
            end
        end
        if (clr) m_ovf[d] = '0;
        else m_ovf[d] = (m_ovf[d] | newovf) & ~((wr && off == 'h2C) ? data[9:0] : 10'd0);
        if (wr && off == 'h28) m_en[d] = data[0];
        m_err[d] = m_sel(a, r, w) && !lg;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                m_edge(0, bus0.W_en, bus0.R_en, bus0.ram_addr, bus0.RW_type, bus0.din, evt0);
                m_edge(1, bus1.W_en, bus1.R_en, bus1.ram_addr, bus1.RW_type, bus1.din, evt1);
            end
        end
    end

    task automatic drive(int d, bit w, bit r, logic [31:0] a, logic [2:0] t,
                         logic [31:0] data, logic [8:0] ev);
        if (d == 0) begin
            bus0.W_en = w; bus0.R_en = r; bus0.ram_addr = a; bus0.RW_type = t; bus0.din = data; evt0 = ev;
        end else begin
            bus1.W_en = w; bus1.R_en = r; bus1.ram_addr = a; bus1.RW_type = t; bus1.din = data; evt1 = ev;
        end
    endtask

    // One bus cycle: drive at negedge, sample combinational outputs, take the edge,
    // then sample the registered error flag.
    task automatic acc(int d, bit w, bit r, logic [31:0] a, logic [2:0] t,
                       logic [31:0] data, logic [8:0] ev);
        @(negedge clk);
        drive(d, w, r, a, t, data, ev);
        #1;
        ed = m_read(d, a, t, r, w);
        es = m_sel(a, r, w);
        od = (d == 0) ? bus0.dout : bus1.dout;
        os = (d == 0) ? bus0.sel : bus1.sel;
        @(posedge clk);
        #1;
        oe = (d == 0) ? bus0.access_err : bus1.access_err;
        ee = m_err[d];
        drive(d, 1'b0, 1'b0, BASE, 3'b010, 32'd0, 9'd0);
    endtask

    task automatic rd(int d, logic [7:0] off);
        acc(d, 1'b0, 1'b1, BASE + {24'd0, off}, RW_WORD, 32'd0, 9'd0);
    endtask

    task automatic wr(int d, logic [7:0] off, logic [31:0] data, logic [8:0] ev);
        acc(d, 1'b1, 1'b0, BASE + {24'd0, off}, RW_WORD, data, ev);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, BASE, 3'b010, 32'd0, 9'd0);
        drive(1, 1'b0, 1'b0, BASE, 3'b010, 32'd0, 9'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] want;
        do_reset();
        n_chk++; if (bus0.access_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus0.access_err); else n_pass++;
        n_chk++; if (bus0.dout !== 32'd0) $display("FAIL reset_dout_idle got %h want 0", bus0.dout); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            rd(0, 8'(4 * i));
            want = (i == 9) ? ed : (i == 10) ? 32'd1 : 32'd0;
            n_chk++; if (od !== want) $display("FAIL reset_reg%0d got %h want %h", i, od, want); else n_pass++;
            n_chk++; if (oe !== 1'b0) $display("FAIL reset_err%0d got %b want 0", i, oe); else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [31:0] want;
        do_reset();
        repeat (5) acc(0, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'd1 << EVT_BEQ);
        repeat (3) acc(0, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'd1 << EVT_JAL);
        for (int i = 0; i < 9; i++) begin
            rd(0, 8'(4 * i));
            want = (i == 0) ? 32'd5 : (i == 6) ? 32'd3 : 32'd0;
            n_chk++; if (od !== want) $display("FAIL basic_cnt%0d got %0d want %0d", i, od, want); else n_pass++;
            n_chk++; if (oe !== 1'b0) $display("FAIL basic_err%0d got %b want 0", i, oe); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (17) acc(1, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'd1 << EVT_BNE);
        rd(1, 8'h04);
        n_chk++; if (od !== 32'd15) $display("FAIL sat4_cnt got %0d want 15", od); else n_pass++;
        rd(1, OFF_OVF);
        n_chk++; if (od[1] !== 1'b1) $display("FAIL sat4_ovf1 got %b want 1", od[1]); else n_pass++;
        wr(1, OFF_OVF, 32'h2, 9'd0);
        rd(1, OFF_OVF);
        n_chk++; if (od[1] !== 1'b0) $display("FAIL sat4_w1c got %b want 0", od[1]); else n_pass++;
        n_chk++; if (od !== ed) $display("FAIL sat4_ovf_all got %h want %h", od, ed); else n_pass++;
        rd(1, 8'h04);
        n_chk++; if (od !== 32'd15) $display("FAIL sat4_hold got %0d want 15", od); else n_pass++;
        wr(0, 8'h08, 32'hFFFF_FFFE, 9'd0);
        repeat (3) acc(0, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'd1 << EVT_BLT);
        rd(0, 8'h08);
        n_chk++; if (od !== 32'hFFFF_FFFF) $display("FAIL sat32_cnt got %h want ffffffff", od); else n_pass++;
        rd(0, OFF_OVF);
        n_chk++; if (od !== 32'h4) $display("FAIL sat32_ovf got %h want 4", od); else n_pass++;
    endtask

    task automatic test_enable();
        longint unsigned snap [10];
        wr(0, OFF_CTRL, 32'h0, 9'd0);
        for (int i = 0; i < 10; i++) snap[i] = m_cnt[0][i];
        repeat (10) acc(0, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'($urandom));
        for (int i = 0; i < 10; i++) begin
            rd(0, 8'(4 * i));
            n_chk++; if (od !== 32'(snap[i])) $display("FAIL dis_cnt%0d got %h want %h", i, od, 32'(snap[i])); else n_pass++;
        end
        wr(0, OFF_CTRL, 32'h3, 9'd0);
        rd(0, OFF_CYCLE);
        n_chk++; if (od !== 32'd0) $display("FAIL clr_cycle got %0d want 0", od); else n_pass++;
        rd(0, OFF_CYCLE);
        n_chk++; if (od !== 32'd1) $display("FAIL resume_cycle got %0d want 1", od); else n_pass++;
        rd(0, OFF_CTRL);
        n_chk++; if (od !== 32'd1) $display("FAIL clr_ctrl got %h want 1", od); else n_pass++;
        rd(0, 8'h08);
        n_chk++; if (od !== 32'd0) $display("FAIL clr_cnt2 got %h want 0", od); else n_pass++;
        wr(0, OFF_CTRL, 32'h2, 9'd0);
        rd(0, OFF_CYCLE);
        rd(0, OFF_CYCLE);
        n_chk++; if (od !== 32'd0) $display("FAIL clr_dis_cycle got %0d want 0", od); else n_pass++;
        rd(0, OFF_CTRL);
        n_chk++; if (od !== 32'd0) $display("FAIL clr_dis_ctrl got %h want 0", od); else n_pass++;
        wr(0, OFF_CTRL, 32'h1, 9'd0);
    endtask

    task automatic test_write_priority();
        wr(0, 8'h00, 32'h100, 9'd1 << EVT_BEQ);
        rd(0, 8'h00);
        n_chk++; if (od !== 32'h100) $display("FAIL wr_wins got %h want 100", od); else n_pass++;
        wr(0, OFF_CYCLE, 32'h1000, 9'd0);
        rd(0, OFF_CYCLE);
        n_chk++; if (od !== 32'h1000) $display("FAIL wr_cycle got %h want 1000", od); else n_pass++;
    endtask

    task automatic test_back_to_back();
        wr(0, 8'h0C, 32'h33, 9'd0);
        acc(0, 1'b1, 1'b1, BASE + 32'h0C, RW_WORD, 32'h55, 9'd0);
        n_chk++; if (od !== 32'h33) $display("FAIL rw_prewrite got %h want 33", od); else n_pass++;
        wr(0, 8'h10, 32'h77, 9'd0);
        rd(0, 8'h0C);
        n_chk++; if (od !== 32'h55) $display("FAIL rw_postwrite got %h want 55", od); else n_pass++;
        rd(0, 8'h10);
        n_chk++; if (od !== 32'h77) $display("FAIL b2b_second got %h want 77", od); else n_pass++;
    endtask

    task automatic test_illegal();
        logic [31:0] snap0;
        snap0 = 32'(m_cnt[0][0]);
        acc(0, 1'b0, 1'b1, BASE, 3'b000, 32'd0, 9'd0);
        n_chk++; if (od !== 32'd0) $display("FAIL lb_dout got %h want 0", od); else n_pass++;
        n_chk++; if (oe !== 1'b1) $display("FAIL lb_err got %b want 1", oe); else n_pass++;
        acc(0, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'd0);
        n_chk++; if (oe !== 1'b0) $display("FAIL err_pulse got %b want 0", oe); else n_pass++;
        acc(0, 1'b1, 1'b0, BASE + 32'h2, RW_WORD, 32'h1234, 9'd0);
        n_chk++; if (oe !== 1'b1) $display("FAIL misalign_err got %b want 1", oe); else n_pass++;
        acc(0, 1'b0, 1'b1, BASE + 32'h40, RW_WORD, 32'd0, 9'd0);
        n_chk++; if (od !== 32'd0) $display("FAIL unmapped_dout got %h want 0", od); else n_pass++;
        n_chk++; if (os !== 1'b1) $display("FAIL unmapped_sel got %b want 1", os); else n_pass++;
        n_chk++; if (oe !== 1'b1) $display("FAIL unmapped_err got %b want 1", oe); else n_pass++;
        acc(0, 1'b0, 1'b1, BASE - 32'h100, RW_WORD, 32'd0, 9'd0);
        n_chk++; if (os !== 1'b0 || oe !== 1'b0) $display("FAIL outside got sel=%b err=%b want 0 0", os, oe); else n_pass++;
        rd(0, 8'h00);
        n_chk++; if (od !== snap0) $display("FAIL illegal_nochange got %h want %h", od, snap0); else n_pass++;
    endtask

    task automatic test_async_reset();
        repeat (4) acc(0, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'h1FF);
        @(negedge clk);
        #3;
        drive(0, 1'b1, 1'b1, BASE + {24'd0, OFF_CYCLE}, RW_WORD, 32'h77, 9'd0);
        drive(1, 1'b0, 1'b1, BASE + 32'h04, RW_WORD, 32'd0, 9'd0);
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus0.dout !== 32'd0) $display("FAIL arst_cycle got %h want 0", bus0.dout); else n_pass++;
        n_chk++; if (bus1.dout !== 32'd0) $display("FAIL arst_cnt4 got %h want 0", bus1.dout); else n_pass++;
        @(posedge clk);
        #2;
        drive(0, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'd0);
        drive(1, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'd0);
        rst_n = 1'b1;
        rd(0, OFF_CTRL);
        n_chk++; if (od !== 32'd1) $display("FAIL arst_en got %h want 1", od); else n_pass++;
        rd(0, OFF_CYCLE);
        n_chk++; if (od !== ed) $display("FAIL arst_dropped_wr got %h want %h", od, ed); else n_pass++;
    endtask

    task automatic test_random();
        bit          w, r;
        logic [31:0] a, data;
        logic [2:0]  t;
        int          op;
        for (int k = 0; k < 400; k++) begin
            w = 1'b0; r = 1'b0; t = RW_WORD; data = $urandom;
            a = BASE + 32'(4 * $urandom_range(0, 11));
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: r = 1'b1;
                4: begin
                    w = 1'b1;
                    a = BASE + 32'(4 * $urandom_range(0, 9));
                    if ($urandom_range(0, 1) == 1) data = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                end
                5: begin
                    w = 1'b1; a = BASE + {24'd0, OFF_CTRL};
                    data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h1;
                end
                6: begin w = 1'b1; a = BASE + {24'd0, OFF_OVF}; data = 32'($urandom_range(0, 1023)); end
                7: begin
                    w = 1'($urandom_range(0, 1));
                    r = !w || ($urandom_range(0, 1) == 1);
                    case ($urandom_range(0, 2))
                        0: t = 3'($urandom_range(0, 7));
                        1: a = a + 32'($urandom_range(1, 3));
                        default: a = BASE + 32'h30 + 32'(4 * $urandom_range(0, 51));
                    endcase
                end
                8: begin w = 1'b1; r = 1'b1; a = BASE + 32'(4 * $urandom_range(0, 9)); end
                default: ;
            endcase
            acc(0, w, r, a, t, data, 9'($urandom));
            n_chk++; if (od !== ed) $display("FAIL rand_dout k=%0d a=%h got %h want %h", k, a, od, ed); else n_pass++;
            n_chk++; if (os !== es) $display("FAIL rand_sel k=%0d got %b want %b", k, os, es); else n_pass++;
            n_chk++; if (oe !== ee) $display("FAIL rand_err k=%0d got %b want %b", k, oe, ee); else n_pass++;
        end
        for (int i = 0; i < 12; i++) begin
            rd(0, 8'(4 * i));
            n_chk++; if (od !== ed) $display("FAIL rand_final%0d got %h want %h", i, od, ed); else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        drive(0, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'd0);
        drive(1, 1'b0, 1'b0, BASE, RW_WORD, 32'd0, 9'd0);
        test_reset();
        test_basic();
        test_saturation();
        test_enable();
        test_write_priority();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
